// File: rtl/gcd_core.sv
// gcd_core: unsigned GCD of an operand pair by repeated subtraction; optional iteration counter under GCD_CYCLE_CNT_EN.
// Latency: N+1 edges after the input handshake for N subtraction steps; 1 edge when either operand is zero.
// Backpressure: one pair in flight; in_ready_o low from capture until the result is taken, result_o held while out_ready_i is low.
module gcd_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o
`ifdef GCD_CYCLE_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] cycles_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;

`ifdef GCD_CYCLE_CNT_EN
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    logic [DATA_WIDTH-1:0] cycle_cnt;

    // Iteration counter: cleared on capture, one count per CALC cycle, saturating, held otherwise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_cnt <= '0;
        end else if (state == IDLE && in_valid_i) begin
            cycle_cnt <= '0;
        end else if (state == CALC && cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
        end
    end

    assign cycles_o = cycle_cnt;
`endif

    // Control FSM with registered handshake/status outputs and the subtract datapath.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            result_o    <= '0;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready_o is high throughout IDLE, so in_valid_i alone is the handshake.
                    if (in_valid_i) begin
                        a          <= operand_a_i;
                        b          <= operand_b_i;
                        in_ready_o <= 1'b0;
                        if (operand_a_i == '0 || operand_b_i == '0) begin
                            result_o    <= operand_a_i | operand_b_i;
                            out_valid_o <= 1'b1;
                            state       <= DONE;
                        end else begin
                            busy_o <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    // The larger operand is always the minuend, so no wrap is possible.
                    if (a == b) begin
                        result_o    <= a;
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else if (a > b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end
                DONE: begin
                    // in_ready_o only rises after this edge, so no new pair shares the output handshake cycle.
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    in_ready_o  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_core.sv
module tb_gcd_core;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          busy;
`ifdef GCD_CYCLE_CNT_EN
    logic [DW-1:0] cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    gcd_core #(.DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .operand_a_i (op_a),
        .operand_b_i (op_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .busy_o      (busy)
`ifdef GCD_CYCLE_CNT_EN
        ,
        .cycles_o    (cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference GCD by Euclid's remainder method.
    function automatic int unsigned ref_gcd(input int unsigned x0, input int unsigned y0);
        int unsigned x = x0;
        int unsigned y = y0;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Sum of Euclid quotients = subtraction steps + 1 = CALC cycles for nonzero operands.
    function automatic int unsigned ref_calc_cycles(input int unsigned x0, input int unsigned y0);
        int unsigned x = x0;
        int unsigned y = y0;
        int unsigned t;
        int unsigned s = 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return s;
    endfunction

    task automatic run_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold, input bit pulse);
        int unsigned exp_lat;
        int unsigned exp_cyc;
        int unsigned lat;
        bit          seen;
        logic [DW-1:0] exp_res;
        string       nm;
        nm = $sformatf("(%0d,%0d)", a, b);
        if (a == 0 || b == 0) begin
            exp_lat = 1;
            exp_cyc = 0;
        end else begin
            exp_lat = ref_calc_cycles(a, b);
            exp_cyc = exp_lat;
        end
        @(negedge clk);
        chk({nm, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        sb.push_back(DW'(ref_gcd(a, b)));
        #1;
        in_valid = 1'b0;
        op_a     = DW'($urandom);
        op_b     = DW'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < exp_lat + 10) begin
            @(posedge clk);
            lat++;
            #1;
            if (pulse && lat == 1) begin
                in_valid = 1'b1;
                op_a     = 16'd100;
                op_b     = 16'd75;
            end
            if (pulse && lat == 3) in_valid = 1'b0;
            if (out_valid) seen = 1'b1;
            else if (lat == 1) begin
                chk({nm, " busy calc"}, busy, 1);
                chk({nm, " in_ready calc"}, in_ready, 0);
            end
        end
        in_valid = 1'b0;
        chk({nm, " latency"}, lat, exp_lat);
        exp_res = sb.pop_front();
        if (seen) begin
            chk({nm, " result"}, result, exp_res);
            chk({nm, " busy done"}, busy, 0);
            chk({nm, " in_ready done"}, in_ready, 0);
`ifdef GCD_CYCLE_CNT_EN
            chk({nm, " cycles"}, cycles, exp_cyc);
`endif
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk({nm, " hold valid"}, out_valid, 1);
                chk({nm, " hold result"}, result, exp_res);
                chk({nm, " hold in_ready"}, in_ready, 0);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({nm, " valid after take"}, out_valid, 0);
            chk({nm, " in_ready after take"}, in_ready, 1);
        end
    endtask

    initial begin
        bit bad;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset result", result, 0);
`ifdef GCD_CYCLE_CNT_EN
        chk("reset cycles", cycles, 0);
`endif
        reset = 1'b0;

        run_pair(16'd12, 16'd8, 0, 1'b0);
        run_pair(16'd0, 16'd9, 0, 1'b0);
        run_pair(16'd0, 16'd0, 0, 1'b0);
        run_pair(16'd9, 16'd0, 0, 1'b0);
        run_pair(16'd7, 16'd7, 0, 1'b0);
        run_pair(16'd48, 16'd18, 5, 1'b0);
        run_pair(16'd35, 16'd21, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            run_pair(DW'($urandom_range(1, 400)), DW'($urandom_range(1, 400)), i, 1'b0);

        // Reset mid-CALC abandons the computation.
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 16'd48;
        op_b     = 16'd18;
        @(posedge clk);
        sb.push_back(16'd6);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(sb.pop_front());
        chk("rst calc out_valid", out_valid, 0);
        chk("rst calc in_ready", in_ready, 1);
        chk("rst calc busy", busy, 0);
        chk("rst calc result", result, 0);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("rst calc stays idle", bad, 0);

        // Reset wins over a simultaneous input handshake.
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        op_a     = 16'd5;
        op_b     = 16'd10;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst prio in_ready", in_ready, 1);
        chk("rst prio busy", busy, 0);
        @(posedge clk);
        #1;
        chk("rst prio no result", out_valid, 0);

        // Reset in DONE drops the pending result.
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 16'd0;
        op_b     = 16'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("done before rst", out_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst done out_valid", out_valid, 0);
        chk("rst done result", result, 0);

        run_pair(16'd1, 16'd65535, 0, 1'b0);

        chk("scoreboard empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_core.md
GCD_CORE -- requirements
Module: gcd_core

Interface
REQ-001 Parameter DATA_WIDTH, default 16: operand and result width in bits, legal range 2..64.
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_i  input  1  reset, synchronous and active-high.
REQ-004 in_valid_i  input  1  operand pair valid.
REQ-005 in_ready_o  output  1  block can accept an operand pair.
REQ-006 operand_a_i  input  DATA_WIDTH  operand A, unsigned.
REQ-007 operand_b_i  input  DATA_WIDTH  operand B, unsigned.
REQ-008 out_valid_o  output  1  result_o holds a completed GCD.
REQ-009 out_ready_i  input  1  downstream accepts the result.
REQ-010 result_o  output  DATA_WIDTH  GCD of the accepted pair.
REQ-011 busy_o  output  1  high while a computation is in progress.
REQ-012 cycles_o  output  DATA_WIDTH  iteration count of the last computation; present only when GCD_CYCLE_CNT_EN is defined.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE: in_ready_o=1, busy_o=0, out_valid_o=0.
- Input handshake: in_valid_i & in_ready_o at a rising edge.
- On handshake, operands are captured into internal registers a and b.
REQ-015 Capture with either operand zero: next state DONE, result = a|b.
- gcd(0,x)=x; gcd(0,0)=0.
REQ-016 Capture with both operands nonzero: next state CALC.
REQ-017 CALC: busy_o=1, in_ready_o=0; exactly one action per cycle:
- a==b: go to DONE, result=a.
- a>b: a<=a-b.
- otherwise: b<=b-a.
REQ-018 Subtraction SHALL be unsigned DATA_WIDTH with no widening; it never underflows because the larger operand is always the minuend.
REQ-019 DONE: out_valid_o=1, busy_o=0, in_ready_o=0.
- result_o stays stable until the output handshake (out_valid_o & out_ready_i).
- After the output handshake: next state IDLE.
REQ-020 Latency: with N = number of subtraction steps, out_valid_o SHALL rise N+1 edges after the input handshake edge; for a zero operand it rises immediately after that edge.
REQ-021 Inputs are ignored outside IDLE; in_valid_i while busy causes no capture and no corruption.
REQ-022 The block SHALL NOT accept a new pair in the same cycle as the output handshake; the next pair is accepted no earlier than the following cycle.
REQ-023 Worst case gcd(1, 2^DATA_WIDTH-1) SHALL complete in 2^DATA_WIDTH-1 CALC cycles, with no timeout.

Reset
REQ-024 reset_i high at a rising edge forces the following values; result_o and cycles_o read 0 until written by a computation:
- state = IDLE
- a = b = 0
- result_o = 0
- out_valid_o = 0
- busy_o = 0
- in_ready_o = 1
- cycles_o = 0
REQ-025 Reset mid-CALC or mid-DONE SHALL abandon the computation and never produce out_valid_o for it.
REQ-026 Reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-027 Macro GCD_CYCLE_CNT_EN defined:
- cycles_o exists.
- The count clears on the input handshake and increments once per CALC cycle, including the equality cycle.
- It saturates at 2^DATA_WIDTH-1 and is held in DONE and IDLE.
REQ-028 Macro GCD_CYCLE_CNT_EN undefined: the cycles_o port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Basic pair: accept (12,8) -> out_valid_o after 3 edges, result_o=4; with the macro defined, cycles_o=3.
REQ-030 Zero operands:
- (0,9): out_valid_o next cycle, result_o=9, cycles_o=0.
- (0,0): result_o=0.
REQ-031 Equal and coprime pairs:
- (7,7): result_o=7 after 1 edge.
- (1,65535) at DATA_WIDTH=16: result_o=1 after 65535 edges.
REQ-032 Backpressure:
- (48,18): result_o=6; hold out_ready_i=0 for 5 cycles.
- result_o and out_valid_o stay stable throughout; in_ready_o=0 throughout.
- in_ready_o rises the cycle after out_ready_i=1.
REQ-033 Busy and reset:
- in_valid_i with (100,75) pulsed during CALC of (35,21) -> result_o=7 only.
- reset_i asserted mid-CALC -> out_valid_o=0, in_ready_o=1 the next cycle.
